// File: rtl/video_fb_scheduler.sv
// video_fb_scheduler: raster timing generator, packed-pixel fetch from a shared
// single-port frame-buffer RAM, and display-priority write arbitration.
// Optional feature: define FB_DOUBLE_BUFFER_EN for a two-page buffer whose
// displayed page swaps at the start of vblank.
module video_fb_scheduler #(
    parameter int unsigned H_DISPLAY    = 256,
    parameter int unsigned V_DISPLAY    = 240,
    parameter int unsigned H_TOTAL      = 309,
    parameter int unsigned V_TOTAL      = 262,
    parameter int unsigned H_SYNC_START = 263,
    parameter int unsigned H_SYNC_END   = 285,
    parameter int unsigned V_SYNC_START = 254,
    parameter int unsigned V_SYNC_END   = 256,
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int unsigned AW          = 16
`else
    localparam int unsigned AW          = 15
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [2:0]    rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          vblank
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    input  logic          swap_req,
    output logic          page
`endif
);

    localparam int unsigned CW = 9;

    localparam logic [CW-1:0] HDisp      = CW'(H_DISPLAY);
    localparam logic [CW-1:0] VDisp      = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HLast      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VLast      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HSyncStart = CW'(H_SYNC_START);
    localparam logic [CW-1:0] HSyncEnd   = CW'(H_SYNC_END);
    localparam logic [CW-1:0] VSyncStart = CW'(V_SYNC_START);
    localparam logic [CW-1:0] VSyncEnd   = CW'(V_SYNC_END);

    // Raster position
    logic [CW-1:0] hpos_q, hpos_d;
    logic [CW-1:0] vpos_q, vpos_d;

    // Two-stage delay pipeline keeping pixels and syncs aligned
    logic       act_dly_q, act_dly_d;
    logic       slot_dly_q, slot_dly_d;
    logic       hs_dly_q, hs_dly_d;
    logic       vs_dly_q, vs_dly_d;
    logic [2:0] hi_q, hi_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    logic          active;
    logic          disp_slot;
    logic          hsync_raw;
    logic          vsync_raw;
    logic [14:0]   disp_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr_eff;

    // Bits 3 and 7 of each byte carry no pixel data
    logic unused_rdata_bits;
    assign unused_rdata_bits = mem_rdata[3] ^ mem_rdata[7];

    assign active    = (hpos_q < HDisp) && (vpos_q < VDisp);
    assign disp_slot = active && !hpos_q[0];
    assign hsync_raw = (hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd);
    assign vsync_raw = (vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd);
    assign disp_addr = {vpos_q[7:0], hpos_q[7:1]};
    assign vblank    = (vpos_q >= VDisp);

`ifdef FB_DOUBLE_BUFFER_EN
    logic page_q, page_d;
    logic swap_pend_q, swap_pend_d;
    logic at_swap;
    logic unused_wr_msb;

    // The page bit replaces the requester's MSB
    assign unused_wr_msb = wr_addr[AW-1];
    assign at_swap       = (hpos_q == '0) && (vpos_q == VDisp);
    assign rd_addr       = {page_q, disp_addr};
    assign wr_addr_eff   = {~page_q, wr_addr[14:0]};
    assign page          = page_q;

    // Sticky swap request, honoured at the first pixel clock of vblank; a request
    // arriving on that very cycle is kept for the following vblank
    always_comb begin
        page_d      = page_q ^ (at_swap & swap_pend_q);
        swap_pend_d = swap_req | (swap_pend_q & ~at_swap);
    end

    // Page state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q      <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            page_q      <= page_d;
            swap_pend_q <= swap_pend_d;
        end
    end
`else
    assign rd_addr     = disp_addr;
    assign wr_addr_eff = wr_addr;
`endif

    // Raster counters: hpos wraps each line, vpos wraps each frame
    always_comb begin
        hpos_d = hpos_q + 1'b1;
        vpos_d = vpos_q;
        if (hpos_q == HLast) begin
            hpos_d = '0;
            vpos_d = (vpos_q == VLast) ? '0 : vpos_q + 1'b1;
        end
    end

    // Arbitration: display slots own the RAM, every other cycle acks the writer.
    // Reset gates the ack so nothing is written while the block is held.
    always_comb begin
        wr_ack    = wr_req & ~disp_slot & ~reset;
        mem_we    = wr_ack;
        mem_wdata = wr_data;
        mem_addr  = rd_addr;
        if (wr_ack) begin
            mem_addr = wr_addr_eff;
        end
    end

    // Pixel and sync pipeline next state. The cycle after a display slot sees the
    // RAM data: low nibble goes out first, high nibble is held for the next cycle.
    always_comb begin
        act_dly_d  = active;
        slot_dly_d = disp_slot;
        hs_dly_d   = hsync_raw;
        vs_dly_d   = vsync_raw;
        hsync_d    = hs_dly_q;
        vsync_d    = vs_dly_q;
        hi_d       = hi_q;
        rgb_d      = hi_q;
        if (slot_dly_q) begin
            rgb_d = mem_rdata[2:0];
            hi_d  = mem_rdata[6:4];
        end
        if (!act_dly_q) begin
            rgb_d = '0;
        end
    end

    // Raster and pipeline state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q     <= '0;
            vpos_q     <= '0;
            act_dly_q  <= 1'b0;
            slot_dly_q <= 1'b0;
            hs_dly_q   <= 1'b0;
            vs_dly_q   <= 1'b0;
            hi_q       <= '0;
            rgb_q      <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            act_dly_q  <= act_dly_d;
            slot_dly_q <= slot_dly_d;
            hs_dly_q   <= hs_dly_d;
            vs_dly_q   <= vs_dly_d;
            hi_q       <= hi_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_video_fb_scheduler.sv
// Bench for video_fb_scheduler: reduced vertical frame (24 lines, 16 active,
// vsync lines 18..20) with full horizontal timing, a registered-read RAM model
// and a queue of expected pixels scored against rgb.
`timescale 1ns/1ps
module tb_video_fb_scheduler;

    localparam int unsigned HT    = 309;
    localparam int unsigned VD    = 16;
    localparam int unsigned VT    = 24;
    localparam int unsigned FRAME = HT * VT;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int unsigned AW = 16;
`else
    localparam int unsigned AW = 15;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [2:0]    rgb;
    logic          hsync;
    logic          vsync;
    logic          vblank;
`ifdef FB_DOUBLE_BUFFER_EN
    logic          swap_req;
    logic          page;
`endif

    video_fb_scheduler #(
        .H_DISPLAY    (256),
        .V_DISPLAY    (VD),
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_SYNC_START (263),
        .H_SYNC_END   (285),
        .V_SYNC_START (18),
        .V_SYNC_END   (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync),
        .vblank    (vblank)
`ifdef FB_DOUBLE_BUFFER_EN
        ,
        .swap_req  (swap_req),
        .page      (page)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM model: unwritten locations read back a fixed pattern
    bit [7:0] ram [0:(1<<AW)-1];
    bit       vld [0:(1<<AW)-1];

    function automatic logic [7:0] pix_init(input logic [14:0] a);
        case (a)
            15'd0:   return 8'h51;
            15'd1:   return 8'h73;
            15'd642: return 8'h00;
            default: return (8'(a * 15'd37) ^ 8'(a >> 7)) | 8'h11;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        return vld[a] ? ram[a] : pix_init(a[14:0]);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            vld[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_rd(mem_addr);
    end

    typedef struct {
        int         due;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    bit   mon_en = 1'b0;
    int   ack_cnt;
    int   hs_first, hs_second, vs_cnt;
    logic hs_prev;
    bit   exp_page, exp_pend;
    logic [2:0] line0_px [0:3];

    function automatic logic [AW-1:0] disp_a(input int h, input int v);
        logic [8:0] hh, vv;
        hh = h[8:0];
        vv = v[8:0];
`ifdef FB_DOUBLE_BUFFER_EN
        return {exp_page, vv[7:0], hh[7:1]};
`else
        return {vv[7:0], hh[7:1]};
`endif
    endfunction

    function automatic logic [AW-1:0] wr_eff(input logic [AW-1:0] a);
`ifdef FB_DOUBLE_BUFFER_EN
        return {~exp_page, a[14:0]};
`else
        return a;
`endif
    endfunction

    // Cycle monitor: model raster position from cycles since reset release
    always @(negedge clk) begin : monitor
        int h, v, h2, v2;
        bit act, slot, ack_exp, hs_exp, vs_exp;
        logic [7:0] b;
        exp_t e;
        if (mon_en) begin
            h    = cyc % HT;
            v    = (cyc / HT) % VT;
            act  = (h < 256) && (v < VD);
            slot = act && (h % 2 == 0);
            if (slot) begin
                b = ram_rd(disp_a(h, v));
                exp_q.push_back('{due: cyc + 2, val: b[2:0]});
                exp_q.push_back('{due: cyc + 3, val: b[6:4]});
                chk("rd_addr", 32'(mem_addr), 32'(disp_a(h, v)));
            end else if (!act) begin
                exp_q.push_back('{due: cyc + 2, val: 3'd0});
            end
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("rgb", 32'(rgb), 32'(e.val));
            end
            hs_exp = 1'b0;
            vs_exp = 1'b0;
            if (cyc >= 2) begin
                h2     = (cyc - 2) % HT;
                v2     = ((cyc - 2) / HT) % VT;
                hs_exp = (h2 >= 263) && (h2 <= 285);
                vs_exp = (v2 >= 18) && (v2 <= 20);
            end
            chk("hsync", 32'(hsync), 32'(hs_exp));
            chk("vsync", 32'(vsync), 32'(vs_exp));
            chk("vblank", 32'(vblank), 32'(v >= VD));
            ack_exp = wr_req && !slot;
            chk("wr_ack", 32'(wr_ack), 32'(ack_exp));
            chk("mem_we", 32'(mem_we), 32'(ack_exp));
            if (ack_exp) begin
                chk("wr_addr", 32'(mem_addr), 32'(wr_eff(wr_addr)));
                chk("wr_data", 32'(mem_wdata), 32'(wr_data));
            end
            if (wr_ack && v == 10 && cyc < FRAME) ack_cnt++;
            if (hsync && !hs_prev) begin
                if (hs_first < 0) hs_first = cyc;
                else if (hs_second < 0) hs_second = cyc;
            end
            hs_prev = hsync;
            if (vsync && cyc < FRAME) vs_cnt++;
`ifdef FB_DOUBLE_BUFFER_EN
            chk("page", 32'(page), 32'(exp_page));
            if (h == 0 && v == VD && exp_pend) begin
                exp_page = ~exp_page;
                exp_pend = 1'b0;
            end
            if (h == 0 && v == VD) exp_pend = 1'b0;
            if (swap_req) exp_pend = 1'b1;
`endif
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    // Release reset just after an edge so cycle 0 is hpos=0, vpos=0
    task automatic start_run();
        @(posedge clk);
        #1;
        exp_q.delete();
        cyc       = 0;
        ack_cnt   = 0;
        hs_first  = -1;
        hs_second = -1;
        hs_prev   = 1'b0;
        vs_cnt    = 0;
        exp_page  = 1'b0;
        exp_pend  = 1'b0;
        reset     = 1'b0;
        mon_en    = 1'b1;
    endtask

    initial begin : stim
        int waited;
        line0_px[0] = 3'd1;
        line0_px[1] = 3'd5;
        line0_px[2] = 3'd3;
        line0_px[3] = 3'd7;
        reset   = 1'b1;
        wr_req  = 1'b1;
        wr_addr = AW'(15'h0A00);
        wr_data = 8'hA5;
`ifdef FB_DOUBLE_BUFFER_EN
        swap_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #3;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        wr_req = 1'b0;

        start_run();
        wait_cyc(2);
        for (int i = 0; i < 4; i++) begin
            chk("line0_px", 32'(rgb), 32'(line0_px[i]));
            step();
        end
        wait_cyc(258);
        chk("blank_258", 32'(rgb), 32'd0);

        // Single write presented on a display slot: one cycle of wait
        wait_cyc(3 * HT + 20);
        wr_addr = AW'(15'd642);
        wr_data = 8'h07;
        wr_req  = 1'b1;
        waited  = 0;
        while (!wr_ack && waited < 4) begin
            step();
            waited++;
        end
        if (!wr_ack) begin
            chk("wr_ack_timeout", 32'(wr_ack), 32'd1);
        end else begin
            step();
        end
        wr_req = 1'b0;
        chk("wr_wait", 32'(waited), 32'd1);
        chk("ram_642", 32'(ram_rd(wr_eff(AW'(15'd642)))), 32'h07);

`ifdef FB_DOUBLE_BUFFER_EN
        wait_cyc(5 * HT);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
`endif

        // Writer held for a whole active line, aimed at an undisplayed line
        wait_cyc(10 * HT);
        wr_addr = AW'(15'h0A00);
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        wait_cyc(11 * HT);
        wr_req = 1'b0;
        chk("line10_acks", 32'(ack_cnt), 32'd181);

        wait_cyc(FRAME);
        chk("hs_first", 32'(hs_first), 32'd265);
        chk("hs_period", 32'(hs_second - hs_first), 32'd309);
        chk("vs_high", 32'(vs_cnt), 32'd927);

        wait_cyc(FRAME + 5 * HT + 6);
        chk("wr_pixel", 32'(rgb), 32'd7);

        // Mid-frame reset on an odd hpos so an unblocked writer would be acked
        wait_cyc(FRAME + 8 * HT + 131);
        wr_addr = AW'(15'h0A00);
        wr_req  = 1'b1;
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("mid_rst_rgb", 32'(rgb), 32'd0);
        chk("mid_rst_hsync", 32'(hsync), 32'd0);
        chk("mid_rst_vsync", 32'(vsync), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_wr_ack", 32'(wr_ack), 32'd0);
        wr_req = 1'b0;
        repeat (3) @(posedge clk);

        start_run();
        wait_cyc(2);
        for (int i = 0; i < 4; i++) begin
            chk("rst_line0_px", 32'(rgb), 32'(line0_px[i]));
            step();
        end
        wait_cyc(600);
        chk("rst_hs_first", 32'(hs_first), 32'd265);
        chk("rgb_queue_drained", 32'(exp_q.size() <= 3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
